crc8_serial_checker: RTL and testbench



---
 rtl/crc8_serial_checker.sv | 67 ++++++
 tb/tb_crc8_serial_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/crc8_serial_checker.sv
// crc8_serial_checker: serial CRC-8 receive checker with frame length and protocol-error reporting
module crc8_serial_checker #(
  parameter logic [7:0] SEED = 8'hD8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Data_In,
  input  logic                 Active,
  input  logic                 CRC_In,
  input  logic                 CRC_Valid,
  output logic                 Check_Done,
  output logic                 CRC_Error,
  output logic                 Frame_Err,
  output logic                 Busy,
  output logic [LEN_WIDTH-1:0] Frame_Len
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t state, state_nx;
  logic [7:0] r, r_nx;
  logic [2:0] cnt, cnt_nx;
  logic [LEN_WIDTH-1:0] len, len_nx;
  logic mis, mis_nx, absorb, abort, last, fb, bit_mis;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state      <= IDLE;
      r          <= SEED;
      cnt        <= '0;
      len        <= '0;
      mis        <= 1'b0;
      Check_Done <= 1'b0;
      CRC_Error  <= 1'b0;
      Frame_Err  <= 1'b0;
      Busy       <= 1'b0;
      Frame_Len  <= '0;
    end else begin
      state      <= state_nx;
      r          <= r_nx;
      cnt        <= cnt_nx;
      len        <= len_nx;
      mis        <= mis_nx;
      Check_Done <= last;
      Frame_Err  <= abort;
      Busy       <= state_nx != IDLE;
      if (last) begin
        CRC_Error <= mis | bit_mis;
        Frame_Len <= len;
      end
    end
  // Active outranks CRC_Valid everywhere; in CHECK it is an abort rather than a data bit
  always_comb begin
    absorb   = state != CHECK && Active;
    abort    = state == CHECK && (Active || !CRC_Valid);
    last     = state == CHECK && !abort && cnt == 3'd7;
    state_nx = abort || last ? IDLE : absorb ? DATA : CRC_Valid ? CHECK : state;
  end
  always_comb begin
    fb      = Data_In ^ r[0];
    bit_mis = CRC_In ^ r[0];
    r_nx    = state_nx == IDLE ? SEED
            : absorb ? {fb, fb ^ r[7], r[6], r[5], r[4], fb ^ r[3], r[2], r[1]}
            : state_nx == CHECK ? r >> 1 : r;
    cnt_nx  = state_nx == CHECK ? (state == CHECK ? cnt + 3'd1 : 3'd1) : 3'd0;
    mis_nx  = state_nx == CHECK && ((state == CHECK && mis) || bit_mis);
    len_nx  = state_nx == IDLE ? '0 : absorb && !(&len) ? len + LEN_WIDTH'(1) : len;
  end
endmodule

// File: tb/tb_crc8_serial_checker.sv
// tb_crc8_serial_checker: directed and random frames against a reflected-polynomial CRC-8 reference
module tb_crc8_serial_checker;
  localparam logic [7:0] SEED = 8'hD8;
  logic CLK = 1'b0, RST = 1'b0, Data_In = 1'b0, Active = 1'b0, CRC_In = 1'b0, CRC_Valid = 1'b0;
  logic Check_Done, CRC_Error, Frame_Err, Busy;
  logic [15:0] Frame_Len;
  logic s_done, s_err, s_ferr, s_busy;
  logic [3:0] s_len;
  int vectors = 0, miscompares = 0, n_done = 0, n_ferr = 0;

  always #5 CLK = ~CLK;

  crc8_serial_checker #(.SEED(SEED), .LEN_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .Data_In(Data_In), .Active(Active), .CRC_In(CRC_In),
    .CRC_Valid(CRC_Valid), .Check_Done(Check_Done), .CRC_Error(CRC_Error),
    .Frame_Err(Frame_Err), .Busy(Busy), .Frame_Len(Frame_Len)
  );

  // narrow length counter exposes saturation within short frames
  crc8_serial_checker #(.SEED(SEED), .LEN_WIDTH(4)) dut_sat (
    .CLK(CLK), .RST(RST), .Data_In(Data_In), .Active(Active), .CRC_In(CRC_In),
    .CRC_Valid(CRC_Valid), .Check_Done(s_done), .CRC_Error(s_err),
    .Frame_Err(s_ferr), .Busy(s_busy), .Frame_Len(s_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (Check_Done) n_done++;
    if (Frame_Err) n_ferr++;
  endtask

  // CRC-8 as bitwise reflected division: poly 0xC4, LSB-first data
  function automatic logic [7:0] ref_crc(input int n, input logic [63:0] d);
    logic [7:0] c;
    c = SEED;
    for (int i = 0; i < n; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 8'hC4 : 8'h00);
    return c;
  endfunction

  task automatic send_data(input int n, input logic [63:0] d, input bit jit);
    for (int i = 0; i < n; i++) begin
      if (jit && i > 0 && $urandom_range(0, 7) == 0) begin
        Active = 1'b0;
        tick();
      end
      Active  = 1'b1;
      Data_In = d[i];
      tick();
      if (i == 0) chk("busy_data", Busy, 1);
    end
    Active  = 1'b0;
    Data_In = 1'b0;
  endtask

  task automatic send_crc(input logic [7:0] c, input int k);
    for (int i = 0; i < k; i++) begin
      CRC_Valid = 1'b1;
      CRC_In    = c[i];
      tick();
      if (i == 0) chk("busy_crc", Busy, 1);
    end
    CRC_Valid = 1'b0;
    CRC_In    = 1'b0;
  endtask

  task automatic frame(input string tag, input int n, input logic [63:0] d, input logic [7:0] c,
                       input int gap, input bit jit, input logic exp_err);
    int d0, f0;
    d0 = n_done;
    f0 = n_ferr;
    send_data(n, d, jit);
    repeat (gap) tick();
    send_crc(c, 8);
    chk({tag, "_done"}, Check_Done, 1);
    chk({tag, "_ndone"}, n_done - d0, 1);
    chk({tag, "_ferr"}, n_ferr - f0, 0);
    chk({tag, "_err"}, CRC_Error, exp_err);
    chk({tag, "_len"}, Frame_Len, n);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_sat_len"}, s_len, n > 15 ? 15 : n);
    chk({tag, "_sat_flags"}, {s_done, s_err, s_ferr, s_busy}, {1'b1, exp_err, 2'b00});
  endtask

  initial begin
    int n, p, d0, f0, gap;
    logic [63:0] d;
    logic [7:0] c;
    logic inj;

    repeat (3) tick();
    chk("rst_done", Check_Done, 0);
    chk("rst_err", CRC_Error, 0);
    chk("rst_ferr", Frame_Err, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_len", Frame_Len, 0);
    RST = 1'b1;
    tick();

    frame("zero_len", 0, 64'd0, 8'hD8, 0, 0, 1'b0);
    tick();
    chk("done_one_cycle", Check_Done, 0);
    frame("bit0_6c", 1, 64'd0, 8'h6C, 2, 0, 1'b0);
    frame("bit1_a8", 1, 64'd1, 8'hA8, 0, 0, 1'b0);
    frame("bit1_a9", 1, 64'd1, 8'hA9, 1, 0, 1'b1);

    d0 = n_done;
    f0 = n_ferr;
    d = 64'hB;
    send_data(4, d, 0);
    send_crc(ref_crc(4, d), 5);
    tick();
    chk("drop_ferr", Frame_Err, 1);
    chk("drop_busy", Busy, 0);
    chk("drop_err_hold", CRC_Error, 1);
    chk("drop_len_hold", Frame_Len, 1);
    tick();
    chk("drop_ferr_pulse", Frame_Err, 0);
    chk("drop_ndone", n_done - d0, 0);
    chk("drop_nferr", n_ferr - f0, 1);

    d0 = n_done;
    f0 = n_ferr;
    d = 64'h5;
    c = ref_crc(3, d);
    send_data(3, d, 0);
    send_crc(c, 3);
    Active    = 1'b1;
    CRC_Valid = 1'b1;
    CRC_In    = c[3];
    tick();
    Active    = 1'b0;
    CRC_Valid = 1'b0;
    chk("act_abort_ferr", Frame_Err, 1);
    chk("act_abort_busy", Busy, 0);
    tick();
    chk("act_abort_ndone", n_done - d0, 0);
    chk("act_abort_nferr", n_ferr - f0, 1);
    d = 64'h13;
    frame("post_abort", 5, d, ref_crc(5, d), 0, 0, 1'b0);

    d0 = n_done;
    f0 = n_ferr;
    send_data(10, 64'h2A5, 0);
    RST = 1'b0;
    tick();
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_err", CRC_Error, 0);
    chk("mid_rst_len", Frame_Len, 0);
    RST = 1'b1;
    tick();
    frame("post_rst", 0, 64'd0, 8'hD8, 0, 0, 1'b0);
    chk("post_rst_nferr", n_ferr - f0, 0);
    chk("post_rst_ndone", n_done - d0, 1);

    d = 64'hDEAD_BEEF_0123_4567;
    c = ref_crc(40, d) ^ 8'h10;
    frame("b2b_a", 40, d, c, 0, 0, 1'b1);
    frame("b2b_b", 64, d, ref_crc(64, d), 0, 0, 1'b0);
    frame("b2b_c", 17, d, ref_crc(17, d), 3, 0, 1'b0);

    for (int f = 0; f < 200; f++) begin
      n   = $urandom_range(1, 64);
      d   = {$urandom, $urandom};
      c   = ref_crc(n, d);
      inj = 1'($urandom_range(0, 1));
      if (inj) begin
        p = $urandom_range(0, n + 7);
        if (p < n) d[p] = ~d[p];
        else c[p-n] = ~c[p-n];
      end
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
      frame("rand", n, d, c, gap, 1, inj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
